// File: rtl/fifo_wptr_full.sv
// fifo_wptr_full: write-clock side of the asynchronous FIFO.
// Holds the binary write pointer (RAM address), publishes a registered
// Gray copy for the read domain, synchronizes the read Gray pointer
// through two flops, and produces a registered full flag plus a sticky
// overflow flag.
// Optional feature macro: FIFO_WPTR_ALMOST_FULL_EN adds a registered
// writer-side fill level and an almost-full flag.
module fifo_wptr_full #(
    parameter int BW_ADDR = 4
`ifdef FIFO_WPTR_ALMOST_FULL_EN
    ,
    parameter int AF_THRESH = 2**BW_ADDR - 2
`endif
) (
    input  logic               in_clk,
    input  logic               in_rst,
    input  logic               in_wr_en,
    input  logic [BW_ADDR:0]   in_rd_gray,
    output logic [BW_ADDR-1:0] out_wr_addr,
    output logic [BW_ADDR:0]   out_wr_gray,
    output logic               out_wr_ack,
    output logic               out_full,
    output logic               out_ovf
`ifdef FIFO_WPTR_ALMOST_FULL_EN
    ,
    output logic [BW_ADDR:0]   out_wr_level,
    output logic               out_almost_full
`endif
);

    function automatic logic [BW_ADDR:0] bin2gray(input logic [BW_ADDR:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [BW_ADDR:0] wr_bin;
    logic [BW_ADDR:0] wr_gray;
    logic [BW_ADDR:0] rq1;
    logic [BW_ADDR:0] rq2;
    logic             full;
    logic             ovf;

    logic [BW_ADDR:0] wr_bin_next;
    logic [BW_ADDR:0] wr_gray_next;
    logic [BW_ADDR:0] full_match;

    // Writes are accepted only while not full; this is also the RAM write enable.
    assign out_wr_ack   = in_wr_en & ~full;
    assign wr_bin_next  = wr_bin + {{BW_ADDR{1'b0}}, out_wr_ack};
    assign wr_gray_next = bin2gray(wr_bin_next);

    // Full when the post-write pointer is exactly one lap ahead of the
    // synchronized read pointer: in Gray code that means the two MSBs
    // inverted and the remaining bits equal.
    assign full_match = {~rq2[BW_ADDR:BW_ADDR-1], rq2[BW_ADDR-2:0]};

    // Write pointer, Gray copy, full and sticky overflow.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            wr_bin  <= '0;
            wr_gray <= '0;
            full    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            wr_bin  <= wr_bin_next;
            wr_gray <= wr_gray_next;
            full    <= (wr_gray_next == full_match);
            ovf     <= ovf | (in_wr_en & full);
        end
    end

    // Two-flop synchronizer for the read-domain Gray pointer.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            rq1 <= '0;
            rq2 <= '0;
        end else begin
            rq1 <= in_rd_gray;
            rq2 <= rq1;
        end
    end

    assign out_wr_addr = wr_bin[BW_ADDR-1:0];
    assign out_wr_gray = wr_gray;
    assign out_full    = full;
    assign out_ovf     = ovf;

`ifdef FIFO_WPTR_ALMOST_FULL_EN
    localparam logic [BW_ADDR:0] AF_LVL = AF_THRESH[BW_ADDR:0];

    function automatic logic [BW_ADDR:0] gray2bin(input logic [BW_ADDR:0] g);
        logic [BW_ADDR:0] b;
        b[BW_ADDR] = g[BW_ADDR];
        for (int i = BW_ADDR - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [BW_ADDR:0] rd_bin;
    logic [BW_ADDR:0] level_next;
    logic [BW_ADDR:0] level;
    logic             almost_full;

    assign rd_bin     = gray2bin(rq2);
    assign level_next = wr_bin_next - rd_bin;

    // Writer-side fill level and almost-full, same latency as full.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            level       <= '0;
            almost_full <= 1'b0;
        end else begin
            level       <= level_next;
            almost_full <= (level_next >= AF_LVL);
        end
    end

    assign out_wr_level    = level;
    assign out_almost_full = almost_full;
`endif

endmodule

// File: tb/tb_fifo_wptr_full.sv
// tb_fifo_wptr_full: directed bench for the FIFO write-pointer / full stage
// with BW_ADDR=4. The almost-full scenario is built only when
// FIFO_WPTR_ALMOST_FULL_EN is defined.
module tb_fifo_wptr_full;

    logic       in_clk = 1'b0;
    logic       in_rst;
    logic       in_wr_en;
    logic [4:0] in_rd_gray;
    logic [3:0] out_wr_addr;
    logic [4:0] out_wr_gray;
    logic       out_wr_ack;
    logic       out_full;
    logic       out_ovf;
`ifdef FIFO_WPTR_ALMOST_FULL_EN
    logic [4:0] out_wr_level;
    logic       out_almost_full;
`endif

    int errors = 0;
    int checks = 0;

    fifo_wptr_full #(
        .BW_ADDR(4)
`ifdef FIFO_WPTR_ALMOST_FULL_EN
        ,
        .AF_THRESH(14)
`endif
    ) dut (
        .in_clk(in_clk),
        .in_rst(in_rst),
        .in_wr_en(in_wr_en),
        .in_rd_gray(in_rd_gray),
        .out_wr_addr(out_wr_addr),
        .out_wr_gray(out_wr_gray),
        .out_wr_ack(out_wr_ack),
        .out_full(out_full),
        .out_ovf(out_ovf)
`ifdef FIFO_WPTR_ALMOST_FULL_EN
        ,
        .out_wr_level(out_wr_level),
        .out_almost_full(out_almost_full)
`endif
    );

    always #5 in_clk = ~in_clk;

    task automatic tick();
        @(posedge in_clk);
        #1;
    endtask

    task automatic test_reset();
        in_rst     = 1'b1;
        in_wr_en   = 1'b1;
        in_rd_gray = 5'b00000;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if ({out_wr_addr, out_wr_gray, out_full, out_ovf} !== 11'd0) begin
                errors++;
                $display("FAIL reset_state cyc=%0d addr=%0d gray=%b full=%b ovf=%b required all 0",
                         c, out_wr_addr, out_wr_gray, out_full, out_ovf);
            end
            checks++;
            if (out_wr_ack !== 1'b1) begin
                errors++;
                $display("FAIL reset_ack_comb got=%b exp=1", out_wr_ack);
            end
`ifdef FIFO_WPTR_ALMOST_FULL_EN
            checks++;
            if ({out_wr_level, out_almost_full} !== 6'd0) begin
                errors++;
                $display("FAIL reset_level level=%0d af=%b exp 0/0", out_wr_level, out_almost_full);
            end
`endif
        end
        in_wr_en = 1'b0;
        in_rst   = 1'b0;
        tick();
        checks++;
        if (out_wr_addr !== 4'd0) begin
            errors++;
            $display("FAIL reset_idle_addr got=%0d exp=0", out_wr_addr);
        end
    endtask

    task automatic test_fill();
        logic [4:0] exp_gray [0:15] = '{5'b00001, 5'b00011, 5'b00010, 5'b00110,
                                        5'b00111, 5'b00101, 5'b00100, 5'b01100,
                                        5'b01101, 5'b01111, 5'b01110, 5'b01010,
                                        5'b01011, 5'b01001, 5'b01000, 5'b11000};
        in_rd_gray = 5'b00000;
        in_wr_en   = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            checks++;
            if (out_wr_ack !== 1'b1 || out_wr_addr !== i[3:0]) begin
                errors++;
                $display("FAIL fill_pre w=%0d ack=%b addr=%0d exp ack=1 addr=%0d",
                         i, out_wr_ack, out_wr_addr, i);
            end
            tick();
            checks++;
            if (out_wr_gray !== exp_gray[i]) begin
                errors++;
                $display("FAIL fill_gray w=%0d got=%b exp=%b", i, out_wr_gray, exp_gray[i]);
            end
            checks++;
            if (out_full !== (i == 15)) begin
                errors++;
                $display("FAIL fill_full w=%0d got=%b exp=%b", i, out_full, (i == 15));
            end
        end
        checks++;
        if (out_wr_addr !== 4'd0) begin
            errors++;
            $display("FAIL fill_addr_wrap got=%0d exp=0", out_wr_addr);
        end
    endtask

    task automatic test_overflow();
        in_wr_en = 1'b1;
        #1;
        checks++;
        if (out_wr_ack !== 1'b0) begin
            errors++;
            $display("FAIL ovf_ack got=%b exp=0", out_wr_ack);
        end
        tick();
        in_wr_en = 1'b0;
        checks++;
        if (out_wr_gray !== 5'b11000 || out_wr_addr !== 4'd0) begin
            errors++;
            $display("FAIL ovf_ptr gray=%b addr=%0d exp 11000/0", out_wr_gray, out_wr_addr);
        end
        checks++;
        if (out_ovf !== 1'b1 || out_full !== 1'b1) begin
            errors++;
            $display("FAIL ovf_flag ovf=%b full=%b exp 1/1", out_ovf, out_full);
        end
    endtask

    task automatic test_release();
        in_rd_gray = 5'b00001;
        for (int e = 0; e < 3; e++) begin
            tick();
            checks++;
            if (out_full !== (e < 2)) begin
                errors++;
                $display("FAIL release_full edge=N+%0d got=%b exp=%b", e, out_full, (e < 2));
            end
        end
        in_wr_en = 1'b1;
        tick();
        in_wr_en = 1'b0;
        checks++;
        if (out_wr_gray !== 5'b11001 || out_full !== 1'b1) begin
            errors++;
            $display("FAIL release_rewrite gray=%b full=%b exp 11001/1", out_wr_gray, out_full);
        end
        // Reader catches up completely: FIFO empty, overflow stays sticky.
        in_rd_gray = 5'b11001;
        repeat (3) tick();
        checks++;
        if (out_full !== 1'b0 || out_ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky full=%b ovf=%b exp 0/1", out_full, out_ovf);
        end
        in_rst = 1'b1;
        tick();
        in_rst = 1'b0;
        checks++;
        if (out_ovf !== 1'b0 || out_wr_gray !== 5'b00000) begin
            errors++;
            $display("FAIL ovf_clear ovf=%b gray=%b exp 0/00000", out_ovf, out_wr_gray);
        end
    endtask

    task automatic test_wrap();
        logic [4:0] prev;
        logic [4:0] exp;
        logic [4:0] rd;
        prev = out_wr_gray;
        for (int k = 0; k < 40; k++) begin
            rd = (k < 2) ? 5'd0 : 5'(k - 2);
            in_rd_gray = rd ^ (rd >> 1);
            in_wr_en   = 1'b1;
            tick();
            exp = 5'(k + 1);
            exp = exp ^ (exp >> 1);
            checks++;
            if (out_wr_gray !== exp || $countones(out_wr_gray ^ prev) != 1) begin
                errors++;
                $display("FAIL wrap_gray w=%0d got=%b prev=%b exp=%b", k, out_wr_gray, prev, exp);
            end
            checks++;
            if (out_full !== 1'b0) begin
                errors++;
                $display("FAIL wrap_full w=%0d got=%b exp=0", k, out_full);
            end
            if (k == 31) begin
                checks++;
                if (out_wr_gray !== 5'b00000) begin
                    errors++;
                    $display("FAIL wrap_zero got=%b exp=00000", out_wr_gray);
                end
            end
            prev = out_wr_gray;
        end
        in_wr_en = 1'b0;
    endtask

`ifdef FIFO_WPTR_ALMOST_FULL_EN
    task automatic test_almost_full();
        in_rst     = 1'b1;
        in_rd_gray = 5'b00000;
        tick();
        in_rst   = 1'b0;
        in_wr_en = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            tick();
            checks++;
            if (out_wr_level !== 5'(i) || out_almost_full !== (i == 14)) begin
                errors++;
                $display("FAIL af_fill w=%0d level=%0d af=%b exp level=%0d af=%b",
                         i, out_wr_level, out_almost_full, i, (i == 14));
            end
        end
        in_wr_en   = 1'b0;
        in_rd_gray = 5'b00001;
        for (int e = 0; e < 3; e++) begin
            tick();
            checks++;
            if (out_almost_full !== (e < 2)) begin
                errors++;
                $display("FAIL af_release edge=N+%0d got=%b exp=%b", e, out_almost_full, (e < 2));
            end
        end
        checks++;
        if (out_wr_level !== 5'd13) begin
            errors++;
            $display("FAIL af_level got=%0d exp=13", out_wr_level);
        end
    endtask
`endif

    initial begin
        in_rst     = 1'b1;
        in_wr_en   = 1'b0;
        in_rd_gray = 5'b00000;
        test_reset();
        test_fill();
        test_overflow();
        test_release();
        test_wrap();
`ifdef FIFO_WPTR_ALMOST_FULL_EN
        test_almost_full();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_wptr_full.md
# fifo_wptr_full

Write-side pointer and full-flag stage of the team's asynchronous FIFO, sitting directly upstream of the dual-port RAM and the read-domain pointer synchronizer. It keeps the binary write pointer that addresses the RAM, and publishes a registered Gray-coded copy of that pointer for the read clock domain. It synchronizes the read domain's Gray pointer into the write clock and produces a registered full flag. Everything runs in the write clock domain.

## Interface
- BW_ADDR, 4, RAM address width; FIFO depth = 2^BW_ADDR; pointers are BW_ADDR+1 bits.
- AF_THRESH, 2^BW_ADDR-2, almost-full threshold in entries; used only when FIFO_WPTR_ALMOST_FULL_EN is defined.

- in_clk  input  1  write-domain clock; all state updates on its rising edge.
- in_rst  input  1  reset, synchronous, active-high.
- in_wr_en  input  1  write request for this cycle.
- in_rd_gray  input  BW_ADDR+1  read pointer, Gray-coded, from the read domain (asynchronous to in_clk).
- out_wr_addr  output  BW_ADDR  RAM write address: binary pointer LSBs.
- out_wr_gray  output  BW_ADDR+1  registered Gray write pointer, for the read domain.
- out_wr_ack  output  1  write accepted this cycle; combinational: in_wr_en & ~out_full.
- out_full  output  1  registered full flag.
- out_ovf  output  1  sticky overflow error.
- out_wr_level  output  BW_ADDR+1  fill level as seen by the writer (macro only).
- out_almost_full  output  1  registered: level >= AF_THRESH (macro only).

## Operation
- State: wr_bin[BW_ADDR:0], wr_gray[BW_ADDR:0], 2-flop synchronizer rq1/rq2[BW_ADDR:0], full, ovf.
- Accept: when out_wr_ack=1, the RAM write uses the current out_wr_addr, and wr_bin increments by 1 at the edge. The increment is modulo 2^(BW_ADDR+1).
- Write while full: request ignored; wr_bin, wr_gray and the RAM address are unchanged; ovf is set. ovf clears only on reset.
- wr_bin_next = wr_bin + out_wr_ack. wr_gray <= wr_bin_next ^ (wr_bin_next >> 1). out_wr_gray is driven straight from the wr_gray register, with no logic after it.
- Synchronizer: rq1 <= in_rd_gray; rq2 <= rq1. No logic between the two flops.
- Full, evaluated every cycle whether or not a write occurs: full <= (gray(wr_bin_next) == {~rq2[BW_ADDR:BW_ADDR-1], rq2[BW_ADDR-2:0]}).
- Full deasserts as soon as rq2 shows read progress, even with no write pending.
- Simultaneous write and read-pointer advance: the full comparison always uses the post-write pointer and the current rq2. Full is never asserted based on a stale pointer for more than the synchronizer latency.
- Reset mid-operation: all state returns to its reset value at the reset edge. Any in-flight request in that cycle is dropped; out_wr_ack still reflects in_wr_en & ~out_full combinationally.
- Reset values: out_wr_addr=0, out_wr_gray=0, out_full=0, out_ovf=0, rq1=rq2=0, out_wr_level=0, out_almost_full=0.

## Timing
- Pointer latency: an accept at edge N updates out_wr_addr, out_wr_gray and out_full at edge N.
- Read-pointer latency:
  - a value stable on in_rd_gray before edge N is captured in rq1 at N and in rq2 at N+1;
  - out_full (and the level outputs) reflect it at edge N+2.
- out_wr_gray changes by exactly one bit per accepted write, including wrap from 2^(BW_ADDR+1)-1 to 0.
- out_wr_ack has no register stage; the RAM write enable is out_wr_ack.

## Configuration
- FIFO_WPTR_ALMOST_FULL_EN defined:
  - a Gray-to-binary conversion of rq2 gives rd_bin;
  - out_wr_level <= wr_bin_next - rd_bin, modulo 2^(BW_ADDR+1);
  - out_almost_full <= (wr_bin_next - rd_bin) >= AF_THRESH;
  - both outputs are registered with the same latency as out_full.
- Undefined: the out_wr_level and out_almost_full ports and their logic are absent, and AF_THRESH is unused. All other behaviour is identical.

## Test plan
All scenarios use BW_ADDR=4.

- Reset: hold in_rst for 2 cycles with in_wr_en=1 → all outputs 0, no address advance.
- Fill: in_rd_gray=0, 16 consecutive writes → out_wr_addr steps 0..15 then 0; out_wr_gray after the 16th write = 5'b11000; out_full=1 at that same edge; out_wr_ack=1 for all 16 writes.
- Overflow: 17th write while full → out_wr_ack=0, out_wr_gray stays 5'b11000, out_ovf=1. out_ovf remains 1 after the FIFO drains, until in_rst.
- Release: while full, set in_rd_gray=5'b00001 before edge N → out_full=0 at N+2, not earlier. The next write gives out_wr_gray=5'b11001 and out_full=1 again.
- Wrap: 40 writes with in_rd_gray tracking the writer two entries behind → out_wr_gray returns to 5'b00000 after 32 writes. Exactly one bit changes per write; out_full never asserts.
- Macro on, AF_THRESH=14, in_rd_gray=0: 14 writes → out_wr_level=14 and out_almost_full=1 on the 14th edge. Advance the reader to 1 → out_almost_full=0 two edges later.
- Macro off: the out_wr_level and out_almost_full ports are absent.
